// File: rtl/ifetch_queue_if.sv
// Fetch-queue bus bundle: instruction-memory request/response and the
// valid/ready instruction stream toward decode.
interface ifetch_queue_if;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_ready;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc,
    input  imem_rdata, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc,
    output imem_rdata, inst_ready
  );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: runs fetches ahead of decode into a DEPTH-entry FIFO,
// flushed by redirect. Define IFQ_BYPASS_EN to forward returning words when empty.
module ifetch_queue #(
  parameter int          DEPTH  = 4,
  parameter logic [63:0] INITPC = 64'h0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         halt,
  input  logic                         redirect,
  input  logic [63:0]                  redirect_pc,
  ifetch_queue_if.master               bus,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [63:0]   r_fetch_pc;
  logic [63:0]   r_inflight_pc;
  logic          r_inflight;
  logic [31:0]   r_inst [DEPTH];
  logic [63:0]   r_pc   [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  logic [CW:0]   w_used;
  logic          w_issue;
  logic          w_ret;
  logic          w_empty;
  logic          w_valid;
  logic          w_push;
  logic          w_pop;

  // An in-flight fetch already owns a slot, so issue only while count+inflight leaves room.
  assign w_used    = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
  assign w_issue   = ~reset & ~halt & ~redirect & (w_used < (CW+1)'(DEPTH));
  assign w_ret     = r_inflight & ~redirect;
  assign w_empty   = (r_count == '0);

  assign bus.imem_req   = w_issue;
  assign bus.imem_addr  = r_fetch_pc;
  assign bus.inst_valid = w_valid;
  assign occupancy      = r_count;

`ifdef IFQ_BYPASS_EN
  logic w_byp;
  assign w_byp       = w_empty & w_ret;
  assign w_valid     = ~w_empty | w_byp;
  assign bus.inst    = w_byp ? bus.imem_rdata : r_inst[r_rd_ptr];
  assign bus.inst_pc = w_byp ? r_inflight_pc  : r_pc[r_rd_ptr];
  // A forwarded word that is accepted never occupies a queue slot.
  assign w_push      = w_ret & ~(w_byp & bus.inst_ready);
  assign w_pop       = w_valid & bus.inst_ready & ~w_byp;
`else
  assign w_valid     = ~w_empty;
  assign bus.inst    = r_inst[r_rd_ptr];
  assign bus.inst_pc = r_pc[r_rd_ptr];
  assign w_push      = w_ret;
  assign w_pop       = w_valid & bus.inst_ready;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc    <= INITPC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_inst[i] <= '0;
        r_pc[i]   <= '0;
      end
    end else if (redirect) begin
      // Queue and the returning word are discarded; a concurrent pop already handed off its entry.
      r_fetch_pc <= redirect_pc & ~64'h3;
      r_inflight <= 1'b0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_pc <= r_fetch_pc;
        r_fetch_pc    <= r_fetch_pc + 64'd4;
      end
      if (w_push) begin
        r_inst[r_wr_ptr] <= bus.imem_rdata;
        r_pc[r_wr_ptr]   <= r_inflight_pc;
        r_wr_ptr         <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: directed vector table, hand-written corner sequences and
// random traffic against a queue-level reference model (honours IFQ_BYPASS_EN).
module tb_ifetch_queue;
  localparam int          DEPTH  = 4;
  localparam logic [63:0] INITPC = 64'h0;

  logic        clk = 1'b0;
  logic        reset;
  logic        halt;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic [2:0]  occupancy;

  ifetch_queue_if dif();

  ifetch_queue #(.DEPTH(DEPTH), .INITPC(INITPC)) dut (
    .clk(clk), .reset(reset), .halt(halt), .redirect(redirect),
    .redirect_pc(redirect_pc), .bus(dif), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memword(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h1357_0000;
  endfunction

  // Synchronous memory: word valid the cycle after a request, junk otherwise.
  always @(posedge clk) begin
    if (dif.imem_req) dif.imem_rdata <= memword(dif.imem_addr);
    else              dif.imem_rdata <= $urandom;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of {inst, pc}, one outstanding fetch, a fetch PC.
  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
  } ent_t;
  ent_t        mq[$];
  bit          m_infl = 1'b0;
  logic [63:0] m_infl_pc = '0;
  logic [63:0] m_fpc = INITPC;

  task automatic drive_in(input logic h, input logic rd, input logic [63:0] rp,
                          input logic rdy, input logic rs);
    @(negedge clk);
    halt = h; redirect = rd; redirect_pc = rp; dif.inst_ready = rdy; reset = rs;
    #1;
  endtask

  task automatic model_cycle(input bit do_chk);
    bit          iss, ret, byp, e_valid, acc;
    logic [31:0] e_inst;
    logic [63:0] e_pc;
    iss = !reset && !halt && !redirect && (mq.size() + int'(m_infl) < DEPTH);
    ret = m_infl && !redirect;
    byp = 1'b0;
`ifdef IFQ_BYPASS_EN
    byp = (mq.size() == 0) && ret;
`endif
    e_valid = (mq.size() != 0) || byp;
    e_inst = '0; e_pc = '0;
    if (byp) begin
      e_inst = memword(m_infl_pc); e_pc = m_infl_pc;
    end else if (mq.size() != 0) begin
      e_inst = mq[0].inst; e_pc = mq[0].pc;
    end
    if (do_chk) begin
      chk("imem_req", 64'(dif.imem_req), 64'(iss));
      chk("imem_addr", dif.imem_addr, m_fpc);
      chk("inst_valid", 64'(dif.inst_valid), 64'(e_valid));
      chk("occupancy", 64'(occupancy), 64'(mq.size()));
      if (e_valid) begin
        chk("inst", 64'(dif.inst), 64'(e_inst));
        chk("inst_pc", dif.inst_pc, e_pc);
      end
    end
    acc = e_valid && dif.inst_ready;
    @(posedge clk);
    if (reset) begin
      mq.delete(); m_infl = 1'b0; m_fpc = INITPC;
    end else if (redirect) begin
      mq.delete(); m_infl = 1'b0; m_fpc = redirect_pc & ~64'h3;
    end else begin
      if (acc && !byp) void'(mq.pop_front());
      if (ret && !(acc && byp)) mq.push_back('{memword(m_infl_pc), m_infl_pc});
      if (iss) begin
        m_infl_pc = m_fpc;
        m_fpc     = m_fpc + 64'd4;
      end
      m_infl = iss;
    end
  endtask

  task automatic step(input logic h, input logic rd, input logic [63:0] rp, input logic rdy);
    drive_in(h, rd, rp, rdy, 1'b0);
    model_cycle(1'b1);
  endtask

  task automatic do_reset();
    drive_in(1'b0, 1'b0, 64'h0, 1'b0, 1'b1);
    model_cycle(1'b1);
  endtask

  typedef struct {
    logic        rdy;
    logic        e_req;
    logic [63:0] e_addr;
    logic        e_valid;
    logic [63:0] e_pc;
    logic [63:0] e_occ;
  } vec_t;
  vec_t tbl[6];

  initial begin
    reset = 1'b1; halt = 1'b0; redirect = 1'b0; redirect_pc = '0;
    dif.inst_ready = 1'b0;

    for (int i = 0; i < 6; i++) begin
`ifdef IFQ_BYPASS_EN
      tbl[i] = '{1'b1, 1'b1, 64'(4 * i), (i >= 1), 64'(4 * (i - 1)), 64'd0};
`else
      tbl[i] = '{1'b1, 1'b1, 64'(4 * i), (i >= 2), 64'(4 * (i - 2)), 64'(i >= 2)};
`endif
    end

    // First reset cycle starts from unknown state; the second one is checked.
    drive_in(1'b0, 1'b0, 64'h0, 1'b0, 1'b1);
    model_cycle(1'b0);
    do_reset();

    // Cold start with ready high.
    for (int i = 0; i < 6; i++) begin
      drive_in(1'b0, 1'b0, 64'h0, tbl[i].rdy, 1'b0);
      if (i == 0) begin
        chk("rst_inst", 64'(dif.inst), 64'h0);
        chk("rst_inst_pc", dif.inst_pc, 64'h0);
      end
      chk("tbl_req", 64'(dif.imem_req), 64'(tbl[i].e_req));
      chk("tbl_addr", dif.imem_addr, tbl[i].e_addr);
      chk("tbl_valid", 64'(dif.inst_valid), 64'(tbl[i].e_valid));
      chk("tbl_occ", 64'(occupancy), tbl[i].e_occ);
      if (tbl[i].e_valid) chk("tbl_pc", dif.inst_pc, tbl[i].e_pc);
      model_cycle(1'b1);
    end

    // Fill to DEPTH with ready low, then drain and resume.
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 64'h0, 1'b0);
    drive_in(1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
    chk("full_occ", 64'(occupancy), 64'd4);
    chk("full_req", 64'(dif.imem_req), 64'd0);
    chk("full_head", dif.inst_pc, 64'h0);
    model_cycle(1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 64'h0, 1'b1);

    // Redirect while the fetch to 0x8 is in flight.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 64'h0, 1'b1);
    step(1'b0, 1'b1, 64'h103, 1'b1);
    drive_in(1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
    chk("redir_occ", 64'(occupancy), 64'd0);
    chk("redir_addr", dif.imem_addr, 64'h100);
    chk("redir_req", 64'(dif.imem_req), 64'd1);
    model_cycle(1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 64'h0, 1'b1);

    // Halt for five cycles with a partly full queue.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 64'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive_in(1'b1, 1'b0, 64'h0, 1'b1, 1'b0);
      chk("halt_req", 64'(dif.imem_req), 64'd0);
      model_cycle(1'b1);
    end
    drive_in(1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
    chk("halt_drained", 64'(occupancy), 64'd0);
    chk("halt_resume", dif.imem_addr, 64'hC);
    model_cycle(1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 64'h0, 1'b1);

    // Fetch PC wraps past the top of the address space.
    step(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
    step(1'b0, 1'b0, 64'h0, 1'b1);
    drive_in(1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
    chk("wrap_addr", dif.imem_addr, 64'h0);
    model_cycle(1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 64'h0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic h, rd, rdy, rs;
      logic [63:0] rp;
      h   = ($urandom_range(7) == 0);
      rd  = ($urandom_range(15) == 0);
      rdy = ($urandom_range(9) < 7);
      rs  = ($urandom_range(199) == 0);
      rp  = {$urandom, $urandom};
      if ($urandom_range(3) == 0) rp = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15));
      drive_in(h, rd, rp, rdy, rs);
      model_cycle(1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
